// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM port arbiter.
package imem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Which requester currently owns the RAM.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  // Byte-enable patterns: single-byte lanes and the full word.
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Width of the RAM latency timer (covers read latencies up to 7).
  localparam int TIMER_W = 3;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that times the RAM read latency window.
// Loaded with LAT-1 on entry to WAIT; last is high once it reaches zero.
module mem_lat_timer
  import imem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_val,
  output logic               last
);

  logic [TIMER_W-1:0] count;

  // Load on request, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbiter sharing one single-ported word RAM between the IF fetch port
// and the MEM load/store port. Data has fixed priority; every access runs
// IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE with one access outstanding.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int LAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_be,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [TIMER_W-1:0] LAT_LOAD = TIMER_W'(LAT - 1);

  state_t              state;
  state_t              next_state;
  owner_t              owner;
  logic [ADDR_W-1:0]   acc_addr;
  logic [3:0]          acc_be;
  logic [DATA_W-1:0]   acc_wdata;
  logic                acc_write;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic [CNT_W-1:0]    conflict_q;
  logic                data_req;
  logic                fetch_blocked;
  logic                timer_last;
  logic                unused_addr_bits;

  assign data_req = d_rd | d_wr;

  // Only the word-address bits reach the RAM; the rest wrap around.
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  mem_lat_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ISSUE),
    .en       (state == ST_WAIT),
    .load_val (LAT_LOAD),
    .last     (timer_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: any request leaves IDLE, WAIT holds until the timer expires.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (data_req || if_req) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (timer_last) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // RAM strobes during ISSUE and completion pulses during DONE.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    case (state)
      ST_ISSUE: begin
        ram_en    = 1'b1;
        ram_addr  = acc_addr;
        ram_wdata = acc_wdata;
        if ((owner == OWN_DATA) && acc_write) ram_we = acc_be;
      end
      ST_DONE: begin
        if_valid = (owner == OWN_FETCH);
        d_valid  = (owner == OWN_DATA);
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  // Grant in IDLE (data first, an rd+wr pair counts as a store) and release after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      acc_addr  <= '0;
      acc_be    <= 4'b0000;
      acc_wdata <= '0;
      acc_write <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (data_req) begin
        owner     <= OWN_DATA;
        acc_addr  <= d_addr[ADDR_W+1:2];
        acc_be    <= d_be;
        acc_wdata <= d_wdata;
        acc_write <= d_wr;
      end else if (if_req) begin
        owner     <= OWN_FETCH;
        acc_addr  <= if_addr[ADDR_W+1:2];
        acc_be    <= 4'b0000;
        acc_wdata <= '0;
        acc_write <= 1'b0;
      end
    end else if (state == ST_DONE) begin
      owner <= OWN_NONE;
    end
  end

  // Capture read data on the last WAIT cycle into the owner's register; stores leave d_rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if ((state == ST_WAIT) && timer_last) begin
      if (owner == OWN_FETCH) begin
        if_rdata_q <= ram_rdata;
      end else if ((owner == OWN_DATA) && !acc_write) begin
        d_rdata_q <= ram_rdata;
      end
    end
  end

  assign fetch_blocked = if_req &&
                         ((owner == OWN_DATA) || ((state == ST_IDLE) && data_req));

  // Saturating count of cycles in which the fetch is held off by data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (fetch_blocked && (conflict_q != '1)) begin
      conflict_q <= conflict_q + CNT_W'(1);
    end
  end

  assign stall_if     = fetch_blocked && !rst;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: directed scenarios plus randomized
// requesters, checked every cycle against a transaction-level model.
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int LAT     = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              d_rd;
  logic              d_wr;
  logic [31:0]       d_addr;
  logic [3:0]        d_be;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              stall_if;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int pass_count  = 0;
  int fail_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (32),
    .LAT    (LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_valid     (if_valid),
    .d_rd         (d_rd),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_be         (d_be),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_valid      (d_valid),
    .stall_if     (stall_if),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .conflict_cnt (conflict_cnt)
  );

  // Reference contents the model expects, and the load strobe that seeds the RAM.
  logic [31:0] ref_mem [64];
  logic        ram_load = 1'b0;

  // RAM model: byte-writable, read data appears LAT cycles after ram_en, junk otherwise.
  logic [31:0] ram_mem [64];
  logic [31:0] rd_pipe [LAT];
  assign ram_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= ram_en ? ram_mem[ram_addr] : $urandom;
    if (ram_load) begin
      for (int w = 0; w < 64; w++) ram_mem[w] <= ref_mem[w];
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Transaction-level model state.
  int          cyc = 0;
  bit          busy = 1'b0;
  int          grant_cyc = 0;
  bit          own_data = 1'b0;
  bit          tx_write = 1'b0;
  logic [ADDR_W-1:0] tx_word = '0;
  logic [3:0]  tx_be = '0;
  logic [31:0] tx_wdata = '0;
  logic [31:0] tx_read = '0;
  logic [31:0] exp_if_data = '0;
  logic [31:0] exp_d_data = '0;
  int          exp_cnt = 0;

  // Requester state.
  bit          fetch_active = 1'b0;
  logic [31:0] fetch_addr = '0;
  bit          data_active = 1'b0;
  bit          data_rd = 1'b0;
  bit          data_wr = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_wdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s cycle %0d: observed=0x%08h expected=0x%08h",
             tag, cyc, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_if_rdata"}, if_rdata, 32'h0);
    checkOutput({tag, "_if_valid"}, if_valid, 32'h0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 32'h0);
    checkOutput({tag, "_d_valid"}, d_valid, 32'h0);
    checkOutput({tag, "_stall_if"}, stall_if, 32'h0);
    checkOutput({tag, "_ram_en"}, ram_en, 32'h0);
    checkOutput({tag, "_ram_we"}, ram_we, 32'h0);
    checkOutput({tag, "_ram_addr"}, ram_addr, 32'h0);
    checkOutput({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    checkOutput({tag, "_conflict_cnt"}, conflict_cnt, 32'h0);
  endtask

  task automatic applyStimulus();
    if_req  = fetch_active;
    if_addr = fetch_addr;
    d_rd    = data_active & data_rd;
    d_wr    = data_active & data_wr;
    d_addr  = data_addr;
    d_be    = data_be;
    d_wdata = data_wdata;
  endtask

  // Compare one cycle against the model, then advance the model past its clock edge.
  task automatic checkCycle();
    bit         idle;
    bit         dreq;
    bit         exp_en;
    bit         exp_ifv;
    bit         exp_dv;
    bit         exp_stall;
    logic [3:0] exp_we;
    idle   = !busy;
    dreq   = d_rd | d_wr;
    exp_en = busy && (cyc == grant_cyc + 1);
    exp_we = 4'b0000;
    if (exp_en) begin
      if (tx_write) begin
        exp_we = tx_be;
        for (int b = 0; b < 4; b++)
          if (tx_be[b]) ref_mem[tx_word][8*b +: 8] = tx_wdata[8*b +: 8];
      end else begin
        tx_read = ref_mem[tx_word];
      end
    end
    exp_ifv = busy && !own_data && (cyc == grant_cyc + LAT + 2);
    exp_dv  = busy &&  own_data && (cyc == grant_cyc + LAT + 2);
    if (exp_ifv) exp_if_data = tx_read;
    if (exp_dv && !tx_write) exp_d_data = tx_read;
    exp_stall = if_req && ((busy && own_data) || (idle && dreq));

    checkOutput("ram_en", ram_en, exp_en);
    checkOutput("ram_we", ram_we, exp_we);
    if (exp_en) checkOutput("ram_addr", ram_addr, tx_word);
    if (exp_en && tx_write) checkOutput("ram_wdata", ram_wdata, tx_wdata);
    checkOutput("if_valid", if_valid, exp_ifv);
    checkOutput("d_valid", d_valid, exp_dv);
    checkOutput("if_rdata", if_rdata, exp_if_data);
    checkOutput("d_rdata", d_rdata, exp_d_data);
    checkOutput("stall_if", stall_if, exp_stall);
    checkOutput("conflict_cnt", conflict_cnt, exp_cnt);

    if (exp_stall && (exp_cnt < CNT_MAX)) exp_cnt++;
    if (exp_ifv) begin
      busy = 1'b0;
      fetch_active = 1'b0;
    end
    if (exp_dv) begin
      busy = 1'b0;
      data_active = 1'b0;
    end
    if (idle && (dreq || if_req)) begin
      busy      = 1'b1;
      grant_cyc = cyc;
      own_data  = dreq;
      if (dreq) begin
        tx_write = d_wr;
        tx_word  = d_addr[ADDR_W+1:2];
        tx_be    = d_be;
        tx_wdata = d_wdata;
      end else begin
        tx_write = 1'b0;
        tx_word  = if_addr[ADDR_W+1:2];
      end
    end
    cyc++;
  endtask

  task automatic runCycle(input int pf, input int pd);
    int kind;
    @(posedge clk);
    #1;
    if (!fetch_active && (int'($urandom_range(0, 99)) < pf)) begin
      fetch_active = 1'b1;
      fetch_addr   = $urandom;
    end
    if (!data_active && (int'($urandom_range(0, 99)) < pd)) begin
      kind        = int'($urandom_range(0, 3));
      data_active = 1'b1;
      data_addr   = $urandom;
      data_wdata  = $urandom;
      data_rd     = (kind == 0) || (kind == 3);
      data_wr     = (kind != 0);
      data_be     = (kind == 1) ? (BE_B0 << data_addr[1:0]) : BE_W;
    end
    applyStimulus();
    @(negedge clk);
    checkCycle();
  endtask

  task automatic forceFetch(input logic [31:0] addr);
    fetch_active = 1'b1;
    fetch_addr   = addr;
  endtask

  task automatic forceData(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
    data_active = 1'b1;
    data_rd     = rd;
    data_wr     = wr;
    data_addr   = addr;
    data_be     = be;
    data_wdata  = wdata;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || fetch_active || data_active) && (n < 60)) begin
      runCycle(0, 0);
      n++;
    end
    if (busy || fetch_active || data_active) begin
      check_count++;
      fail_count++;
      $error("[TB] FAIL drain_timeout cycle %0d: observed=busy expected=idle", cyc);
    end
  endtask

  // Asynchronous reset landing mid-cycle; outputs must clear at once.
  task automatic doReset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero(tag);
    fetch_active = 1'b0;
    data_active  = 1'b0;
    applyStimulus();
    busy        = 1'b0;
    exp_if_data = '0;
    exp_d_data  = '0;
    exp_cnt     = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int w = 0; w < 64; w++) ref_mem[w] = $urandom;
    ref_mem[0] = 32'h0000_0014;
    ref_mem[1] = 32'h0000_0009;
    ref_mem[2] = 32'h0000_0083;
    ram_load = 1'b1;
    applyStimulus();
    #2 rst = 1'b1;
    #1 checkAllZero("reset");
    @(posedge clk);
    #1;
    ram_load = 1'b0;
    rst = 1'b0;

    $display("[TB] fetch only");
    forceFetch(32'h0000_0008);
    drain();
    checkOutput("fetch_rdata", if_rdata, 32'h0000_0083);

    $display("[TB] load and fetch together");
    forceData(1'b1, 1'b0, 32'h0000_0004, BE_W, 32'h0);
    forceFetch(32'h0000_0000);
    drain();
    checkOutput("race_d_rdata", d_rdata, 32'h0000_0009);
    checkOutput("race_if_rdata", if_rdata, 32'h0000_0014);
    checkOutput("race_conflict", conflict_cnt, LAT + 3);

    $display("[TB] byte store then load");
    forceData(1'b0, 1'b1, 32'h0000_0001, 4'b0010, 32'h0000_1D00);
    drain();
    forceData(1'b1, 1'b0, 32'h0000_0000, BE_W, 32'h0);
    drain();
    checkOutput("sb_then_load", d_rdata, 32'h0000_1D14);

    $display("[TB] read and write together");
    forceData(1'b1, 1'b1, 32'h0000_0010, BE_W, 32'hCAFE_F00D);
    drain();
    checkOutput("rdwr_keeps_rdata", d_rdata, 32'h0000_1D14);
    forceData(1'b1, 1'b0, 32'h0000_0010, BE_W, 32'h0);
    drain();
    checkOutput("rdwr_committed", d_rdata, 32'hCAFE_F00D);

    $display("[TB] reset during fetch wait");
    forceFetch(32'h0000_0010);
    runCycle(0, 0);
    runCycle(0, 0);
    runCycle(0, 0);
    doReset("mid_reset");
    forceFetch(32'h0000_0010);
    drain();
    checkOutput("fetch_after_reset", if_rdata, 32'hCAFE_F00D);

    $display("[TB] back-to-back fetches");
    forceFetch(32'h0000_0000);
    drain();
    forceFetch(32'h0000_0004);
    drain();
    checkOutput("b2b_if_rdata", if_rdata, 32'h0000_0009);
    checkOutput("b2b_conflict", conflict_cnt, 32'h0);

    $display("[TB] starved fetch saturates the counter");
    for (int i = 0; i < 60; i++) runCycle(100, 100);
    checkOutput("conflict_saturated", conflict_cnt, CNT_MAX);
    drain();

    $display("[TB] random traffic");
    doReset("reset_before_random");
    for (int i = 0; i < 500; i++) runCycle(35, 35);
    drain();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
